// File: rtl/sequenciador_movimentos_pkg.sv
// Shared definitions for the move sequencer: FSM state codes, default sizes
// and the rule that marks the end of a received move list.
package sequenciador_movimentos_pkg;

    localparam int DEFAULT_DEPTH  = 480;
    localparam int DEFAULT_MOVE_W = 3;
    localparam int DEFAULT_ADDR_W = 9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // A byte terminates the list when its low moveW bits are all ones.
    function automatic logic isEndCode(input logic [7:0] dado, input int moveW);
        logic allOnes;
        allOnes = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (b < moveW) begin
                allOnes = allOnes & dado[b];
            end
        end
        return allOnes;
    endfunction

endpackage

// File: rtl/ram_movimentos_n.sv
// Move buffer: one write port and one registered read port. Contents are
// never cleared; the sequencer's move count decides which entries are valid.
module ram_movimentos_n
    import sequenciador_movimentos_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int MOVE_W = DEFAULT_MOVE_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [MOVE_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [MOVE_W-1:0] rdata_o
);

    logic [MOVE_W-1:0] mem [0:DEPTH-1];
    logic [MOVE_W-1:0] rdata_q;

    // Write when requested and always register the addressed word for reading.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sequenciador_movimentos.sv
// Move sequencer: loads a list of move codes from a byte stream, then plays
// them back one at a time to the servo manager, waiting for each to finish.
module sequenciador_movimentos
    import sequenciador_movimentos_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int MOVE_W = DEFAULT_MOVE_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              carregar,
    input  logic              rx_valid,
    input  logic [7:0]        rx_dado,
    input  logic              executar,
    input  logic              pausar,
    input  logic              mov_pronto,
    output logic              mov_iniciar,
    output logic [MOVE_W-1:0] movimento,
    output logic [ADDR_W:0]   num_movimentos,
    output logic [ADDR_W:0]   indice,
    output logic              movimento_par,
    output logic              carregado,
    output logic              fim,
    output logic              erro_overflow,
    output logic [2:0]        db_estado
);

    localparam logic [ADDR_W:0] DEPTH_N = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_N   = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   numMov_q, numMov_d;
    logic [ADDR_W:0]   indice_q, indice_d;
    logic [MOVE_W-1:0] movimento_q, movimento_d;
    logic              iniciar_q, iniciar_d;
    logic              fim_q, fim_d;
    logic              carregado_q, carregado_d;
    logic              erro_q, erro_d;

    logic              ramWe;
    logic [ADDR_W-1:0] ramWaddr;
    logic [MOVE_W-1:0] ramWdata;
    logic [MOVE_W-1:0] ramRdata;
    logic [ADDR_W:0]   indiceInc;
    logic              rxIsEnd;

    assign indiceInc = indice_q + ONE_N;
    assign rxIsEnd   = isEndCode(rx_dado, MOVE_W);

    // The read address follows the next index so the word is ready in ISSUE.
    ram_movimentos_n #(
        .DEPTH  (DEPTH),
        .MOVE_W (MOVE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock_i (clock),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i (ramWdata),
        .raddr_i (indice_d[ADDR_W-1:0]),
        .rdata_o (ramRdata)
    );

    // Next-state logic: carregar overrides everything and restarts loading.
    always_comb begin
        state_d     = state_q;
        numMov_d    = numMov_q;
        indice_d    = indice_q;
        movimento_d = movimento_q;
        iniciar_d   = 1'b0;
        fim_d       = 1'b0;
        carregado_d = carregado_q;
        erro_d      = erro_q;
        ramWe       = 1'b0;
        ramWaddr    = numMov_q[ADDR_W-1:0];
        ramWdata    = rx_dado[MOVE_W-1:0];

        if (carregar) begin
            state_d     = ST_LOAD;
            numMov_d    = '0;
            carregado_d = 1'b0;
            erro_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        if (rxIsEnd) begin
                            if (numMov_q != '0) begin
                                state_d     = ST_READY;
                                carregado_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else if (numMov_q == DEPTH_N) begin
                            erro_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ramWe    = 1'b1;
                            numMov_d = numMov_q + ONE_N;
                        end
                    end
                end
                ST_READY, ST_DONE: begin
                    if (executar) begin
                        indice_d = '0;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!pausar) begin
                        iniciar_d   = 1'b1;
                        movimento_d = ramRdata;
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mov_pronto) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    indice_d = indiceInc;
                    if (indiceInc == numMov_q) begin
                        fim_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            numMov_q    <= '0;
            indice_q    <= '0;
            movimento_q <= '0;
            iniciar_q   <= 1'b0;
            fim_q       <= 1'b0;
            carregado_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            numMov_q    <= numMov_d;
            indice_q    <= indice_d;
            movimento_q <= movimento_d;
            iniciar_q   <= iniciar_d;
            fim_q       <= fim_d;
            carregado_q <= carregado_d;
            erro_q      <= erro_d;
        end
    end

    assign mov_iniciar    = iniciar_q;
    assign movimento      = movimento_q;
    assign num_movimentos = numMov_q;
    assign indice         = indice_q;
    assign movimento_par  = ~indice_q[0];
    assign carregado      = carregado_q;
    assign fim            = fim_q;
    assign erro_overflow  = erro_q;
    assign db_estado      = state_q;

endmodule

// File: doc/sequenciador_movimentos.md
SEQUENCIADOR_MOVIMENTOS -- requirements
Module: sequenciador_movimentos

Interface
REQ-001 SHALL have parameter DEPTH, default 480, meaning move-buffer capacity in entries.
REQ-002 SHALL have parameter MOVE_W, default 3, meaning move-code width in bits.
REQ-003 SHALL have parameter ADDR_W, default 9, meaning buffer address width, with 2^ADDR_W >= DEPTH.
REQ-004 SHALL have port clock  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port carregar  in  1  pulse: clear the buffer and enter load mode.
REQ-007 SHALL have port rx_valid  in  1  one-cycle strobe: rx_dado holds a received byte.
REQ-008 SHALL have port rx_dado  in  8  received byte; bits [MOVE_W-1:0] are the move code.
REQ-009 SHALL have port executar  in  1  pulse: start playback from index 0.
REQ-010 SHALL have port pausar  in  1  level: hold before issuing the next move.
REQ-011 SHALL have port mov_pronto  in  1  pulse from the servo manager: current move finished.
REQ-012 SHALL have port mov_iniciar  out  1  one-cycle pulse to the servo manager.
REQ-013 SHALL have port movimento  out  MOVE_W  move code being issued or held.
REQ-014 SHALL have port num_movimentos  out  ADDR_W+1  number of moves stored.
REQ-015 SHALL have port indice  out  ADDR_W+1  index of the current playback move.
REQ-016 SHALL have port movimento_par  out  1  high when indice is even.
REQ-017 SHALL have port carregado  out  1  high while a terminated, non-empty list is held.
REQ-018 SHALL have port fim  out  1  one-cycle pulse when playback completes.
REQ-019 SHALL have port erro_overflow  out  1  sticky flag: a load exceeded DEPTH.
REQ-020 SHALL have port db_estado  out  3  current FSM state encoding.

Function
REQ-021 FSM states SHALL be IDLE=0, LOAD=1, READY=2, ISSUE=3, WAIT=4, NEXT=5, DONE=6.
REQ-022 From IDLE, READY or DONE, carregar SHALL zero num_movimentos, clear carregado and erro_overflow, and enter LOAD on the next cycle.
REQ-023 In LOAD, each rx_valid with code != all-ones SHALL write the code at address num_movimentos and increment num_movimentos by 1.
REQ-024 In LOAD, an all-ones code (END) SHALL not be stored; the FSM SHALL go to READY with carregado=1 if num_movimentos>0, otherwise to IDLE.
REQ-025 In LOAD, rx_valid with num_movimentos==DEPTH and a non-END code SHALL set erro_overflow, leave the buffer unchanged, and move the FSM to IDLE.
REQ-026 In READY or DONE, executar SHALL zero indice and enter ISSUE; executar SHALL be ignored in IDLE and LOAD.
REQ-027 In ISSUE, with pausar=0, the FSM SHALL assert mov_iniciar for exactly one cycle, present buffer[indice] on movimento, and enter WAIT; with pausar=1 it SHALL remain in ISSUE.
REQ-028 The buffer SHALL use a synchronous read; the read address SHALL be driven one cycle ahead so that movimento is valid in the same cycle as mov_iniciar.
REQ-029 movimento SHALL stay stable from mov_iniciar until the cycle after mov_pronto.
REQ-030 In WAIT, mov_pronto SHALL cause entry to NEXT; mov_pronto in any other state SHALL be ignored.
REQ-031 In NEXT, indice SHALL increment; if the new indice == num_movimentos, the FSM SHALL pulse fim and enter DONE, otherwise it SHALL enter ISSUE.
REQ-032 movimento_par SHALL equal ~indice[0] combinationally.
REQ-033 carregar received during ISSUE, WAIT or NEXT SHALL abort playback, suppressing fim, and begin a new load; the servo manager is expected to finish its current move on its own.
REQ-034 Simultaneous carregar and executar SHALL give carregar priority.
REQ-035 Buffer contents SHALL persist across playbacks; DONE followed by executar SHALL replay the same list.

Reset
REQ-036 On reset=1 at a clock edge, the block SHALL enter IDLE; num_movimentos, indice and movimento SHALL be 0, and mov_iniciar, fim, carregado and erro_overflow SHALL be 0.
REQ-037 Buffer RAM contents SHALL not need clearing on reset; num_movimentos=0 invalidates them.
REQ-038 Reset SHALL take priority over every other input, including a reset mid-playback.

Structure
REQ-039 A shared package SHALL hold the FSM state encodings, the END-code rule (all-ones of MOVE_W), and the default DEPTH and MOVE_W values.
REQ-040 The buffer SHALL be a single sub-module ram_movimentos_n (parameters DEPTH, MOVE_W, ADDR_W; 1 write port, 1 synchronous read port); the FSM and counters SHALL stay in the top module.

Verification
REQ-041 SHALL cover: carregar, bytes 0x01,0x02,0x05,0x07 -> num_movimentos=3, carregado=1, state READY.
REQ-042 SHALL cover: executar, with a servo model answering mov_pronto 10 cycles after each mov_iniciar -> movimento 1,2,5 in order; movimento_par 1,0,1; one fim pulse; state DONE.
REQ-043 SHALL cover: DEPTH=4 and 5 non-END bytes -> erro_overflow=1, num_movimentos=4, state IDLE; a later carregar clears erro_overflow.
REQ-044 SHALL cover: pausar=1 during WAIT of move 0 -> no mov_iniciar until pausar=0; then move 1 is issued within 2 cycles.
REQ-045 SHALL cover: carregar during WAIT, then reset asserted in LOAD -> no fim; after reset all outputs are 0 and the state is IDLE.
REQ-046 SHALL cover: END as the first byte -> state IDLE, carregado=0; a following executar is ignored (no mov_iniciar).
